// File: rtl/conv_accum_stage.sv
// conv_accum_stage: 3x3 convolution accumulate / requantize stage.
// A 3-stage arithmetic pipeline feeds an output FIFO whose head entry
// is held in the out_* registers.
// Optional build macro CONV_RELU_EN: the output is clipped to 0..255 as
// unsigned (ReLU). Without it, the output is clipped to -128..127 as
// two's complement.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. in_ready does not depend on in_valid. out_* are
// registered, and they stay stable while out_valid=1 and out_ready=0.
module conv_accum_stage #(
  parameter int M     = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] d11,
  input  logic [2*M-1:0] d12,
  input  logic [2*M-1:0] d13,
  input  logic [2*M-1:0] d21,
  input  logic [2*M-1:0] d22,
  input  logic [2*M-1:0] d23,
  input  logic [2*M-1:0] d31,
  input  logic [2*M-1:0] d32,
  input  logic [2*M-1:0] d33,
  input  logic [15:0]    bias,
  input  logic [4:0]     in_row,
  input  logic [4:0]     in_col,
  input  logic           in_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic [4:0]     out_row,
  output logic [4:0]     out_col,
  output logic           out_done,
  output logic [15:0]    sat_cnt
);

  localparam int AW  = 20;
  localparam int AWI = $clog2(DEPTH);
  localparam int CW  = AWI + 1;
  localparam int FW  = 19;
  localparam int RND = 1 << (SHIFT - 1);

  function automatic logic signed [AW-1:0] sx(input logic [2*M-1:0] v);
    return AW'($signed(v));
  endfunction

  // Pipeline registers
  logic                 r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [AW-1:0] r_s1_ps0, r_s1_ps1, r_s1_ps2, r_s1_ps3, r_s1_ps4;
  logic [15:0]          r_s1_bias;
  logic signed [AW-1:0] r_s2_acc;
  logic [7:0]           r_s3_data;
  logic [4:0]           r_s1_row, r_s1_col, r_s2_row, r_s2_col, r_s3_row, r_s3_col;
  logic                 r_s1_done, r_s2_done, r_s3_done;

  // FIFO storage, and the head entry register
  logic [FW-1:0]        r_mem [DEPTH];
  logic [AWI-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_mem_cnt;
  logic                 r_out_valid;
  logic [7:0]           r_out_data;
  logic [4:0]           r_out_row, r_out_col;
  logic                 r_out_done;
  logic [15:0]          r_sat_cnt;

  logic                 w_in_fire, w_push, w_pop, w_load, w_sat, w_inc, w_clr;
  logic signed [AW:0]   w_round, w_r;
  logic [7:0]           w_clip;
  logic [CW:0]          w_occ;
  logic [FW-1:0]        w_head;

  assign w_in_fire = in_valid & in_ready;
  assign w_push    = r_s3_valid;
  assign w_pop     = r_out_valid & out_ready;
  assign w_load    = (r_mem_cnt != '0) && (!r_out_valid || w_pop);
  assign w_head    = r_mem[r_rd_ptr];

  // Everything already accepted and not yet popped is counted, so FIFO overflow cannot occur.
  assign w_occ    = (CW+1)'(r_mem_cnt) + (CW+1)'(r_out_valid) + (CW+1)'(r_s1_valid)
                  + (CW+1)'(r_s2_valid) + (CW+1)'(r_s3_valid);
  assign in_ready = w_occ < (CW+1)'(DEPTH);

  // Rounding, arithmetic shift, and clipping of the stage-2 accumulator.
  // The accumulator is widened by one bit so that adding the rounding term cannot wrap.
  assign w_round = (AW+1)'(r_s2_acc) + (AW+1)'(RND);
  assign w_r     = w_round >>> SHIFT;

  // Clip to the output range, and flag results that are counted as saturated
  always_comb begin
    w_clip = w_r[7:0];
    w_sat  = 1'b0;
`ifdef CONV_RELU_EN
    if (w_r < 0) begin
      w_clip = 8'h00;
    end else if (w_r > 21'sd255) begin
      w_clip = 8'hFF;
      w_sat  = 1'b1;
    end
`else
    if (w_r > 21'sd127) begin
      w_clip = 8'h7F;
      w_sat  = 1'b1;
    end else if (w_r < -21'sd128) begin
      w_clip = 8'h80;
      w_sat  = 1'b1;
    end
`endif
  end

  assign w_inc = r_s2_valid & w_sat;
  assign w_clr = w_pop & r_out_done;

  // Pipeline valid bits: the pipe never stalls, so each stage takes the previous stage every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Pipeline data: partial sums, then the accumulator, then the clipped result, with tags alongside
  always_ff @(posedge clk) begin
    r_s1_ps0  <= sx(d11) + sx(d12);
    r_s1_ps1  <= sx(d13) + sx(d21);
    r_s1_ps2  <= sx(d22) + sx(d23);
    r_s1_ps3  <= sx(d31) + sx(d32);
    r_s1_ps4  <= sx(d33);
    r_s1_bias <= bias;
    r_s1_row  <= in_row;
    r_s1_col  <= in_col;
    r_s1_done <= in_done;
    r_s2_acc  <= r_s1_ps0 + r_s1_ps1 + r_s1_ps2 + r_s1_ps3 + r_s1_ps4
               + AW'($signed(r_s1_bias));
    r_s2_row  <= r_s1_row;
    r_s2_col  <= r_s1_col;
    r_s2_done <= r_s1_done;
    r_s3_data <= w_clip;
    r_s3_row  <= r_s2_row;
    r_s3_col  <= r_s2_col;
    r_s3_done <= r_s2_done;
  end

  // FIFO memory write, from the stage-3 result
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_s3_done, r_s3_row, r_s3_col, r_s3_data};
  end

  // FIFO pointers, occupancy, and the registered head entry that drives out_*
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_done  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_load);
      if (w_load) begin
        r_out_valid <= 1'b1;
        {r_out_done, r_out_row, r_out_col, r_out_data} <= w_head;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Saturation counter: it sticks at all-ones, and clears after a frame's last pixel leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (w_clr) begin
      r_sat_cnt <= w_inc ? 16'd1 : 16'd0;
    end else if (w_inc && r_sat_cnt != 16'hFFFF) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign out_done  = r_out_done;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_conv_accum_stage.sv
// Testbench for conv_accum_stage: directed vectors, backpressure,
// reset in the middle of operation, and a random handshake run.
module tb_conv_accum_stage;
  localparam int M     = 8;
  localparam int SHIFT = 4;
  localparam int DEPTH = 8;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0, in_ready, in_done = 1'b0;
  logic [2*M-1:0] d11 = '0, d12 = '0, d13 = '0, d21 = '0, d22 = '0;
  logic [2*M-1:0] d23 = '0, d31 = '0, d32 = '0, d33 = '0;
  logic [15:0]    bias = '0;
  logic [4:0]     in_row = '0, in_col = '0;
  logic           out_valid, out_ready = 1'b0, out_done;
  logic [7:0]     out_data;
  logic [4:0]     out_row, out_col;
  logic [15:0]    sat_cnt;

  conv_accum_stage #(.M(M), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d11(d11), .d12(d12), .d13(d13), .d21(d21), .d22(d22), .d23(d23),
    .d31(d31), .d32(d32), .d33(d33), .bias(bias),
    .in_row(in_row), .in_col(in_col), .in_done(in_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_done(out_done), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic [8:0][15:0] p;
    logic [15:0]      b;
    logic [4:0]       row, col;
    logic             done;
    logic [7:0]       exp_s, exp_r;
    logic [15:0]      sat_s, sat_r;
  } vec_t;

  vec_t        vecs[12];
  logic [18:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: full-precision integer sum, rounding shift, clip
  function automatic logic [7:0] model(input logic [8:0][15:0] p, input logic [15:0] b);
    int acc, r;
    acc = int'($signed(b));
    for (int k = 0; k < 9; k++) acc += int'($signed(p[k]));
    r = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
    if (RELU) begin
      if (r < 0) r = 0;
      else if (r > 255) r = 255;
    end else begin
      if (r > 127) r = 127;
      else if (r < -128) r = -128;
    end
    return r[7:0];
  endfunction

  function automatic vec_t mk(input logic [15:0] v, input logic [15:0] b, input int row,
                              input int col, input logic done, input logic [7:0] es,
                              input logic [7:0] er, input logic [15:0] ss, input logic [15:0] sr);
    vec_t t;
    for (int k = 0; k < 9; k++) t.p[k] = v;
    t.b = b; t.row = 5'(row); t.col = 5'(col); t.done = done;
    t.exp_s = es; t.exp_r = er; t.sat_s = ss; t.sat_r = sr;
    return t;
  endfunction

  // Driver: put one product set on the input bus (in_valid is handled separately)
  task automatic drive_set(input logic [8:0][15:0] p, input logic [15:0] b,
                           input logic [4:0] row, input logic [4:0] col, input logic done);
    d11 = p[0]; d12 = p[1]; d13 = p[2]; d21 = p[3]; d22 = p[4];
    d23 = p[5]; d31 = p[6]; d32 = p[7]; d33 = p[8];
    bias = b; in_row = row; in_col = col; in_done = done;
  endtask

  // Send one vector into an empty stage, check the exact latency and the fields, then pop it
  task automatic apply_vec(input vec_t v, input int idx);
    logic [7:0]  e_data;
    logic [15:0] e_sat;
    string       tag;
    e_data = RELU ? v.exp_r : v.exp_s;
    e_sat  = RELU ? v.sat_r : v.sat_s;
    tag    = $sformatf("vec%0d", idx);
    drive_set(v.p, v.b, v.row, v.col, v.done);
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e_data));
    chk({tag, "_row"}, 32'(out_row), 32'(v.row));
    chk({tag, "_col"}, 32'(out_col), 32'(v.col));
    chk({tag, "_done"}, 32'(out_done), 32'(v.done));
    chk({tag, "_sat"}, 32'(sat_cnt), 32'(e_sat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    chk({tag, "_sat_after"}, 32'(sat_cnt), v.done ? 32'd0 : 32'(e_sat));
  endtask

  // Watchdog timer
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0][15:0] p;
    logic [15:0]      b;
    logic [4:0]       row, col;
    int               acc_n, popped, cyc, stale, sent, got;

    // Vector table: expected values for signed and ReLU builds, and cumulative sat_cnt
    vecs[0]  = mk(16'h0010, 16'h0000,  3,  7, 1'b0, 8'h09, 8'h09, 16'd0, 16'd0);
    vecs[1]  = mk(16'hFFF0, 16'h0000,  1,  2, 1'b0, 8'hF7, 8'h00, 16'd0, 16'd0);
    vecs[2]  = mk(16'h1000, 16'h0000,  4,  5, 1'b1, 8'h7F, 8'hFF, 16'd1, 16'd1);
    vecs[3]  = mk(16'h0000, 16'h0064,  6,  8, 1'b0, 8'h09, 8'h09, 16'd0, 16'd0);
    for (int k = 0; k < 9; k++) vecs[3].p[k] = 16'(k + 1);
    vecs[4]  = mk(16'h0000, 16'hFF38,  7,  9, 1'b0, 8'hF4, 8'h00, 16'd0, 16'd0);
    vecs[5]  = mk(16'h0000, 16'h0008,  8, 10, 1'b0, 8'h01, 8'h01, 16'd0, 16'd0);
    vecs[6]  = mk(16'h0000, 16'h07F0,  9, 11, 1'b0, 8'h7F, 8'h7F, 16'd0, 16'd0);
    vecs[7]  = mk(16'h0000, 16'h07F8, 10, 12, 1'b0, 8'h7F, 8'h80, 16'd1, 16'd0);
    vecs[8]  = mk(16'h0000, 16'hF800, 11, 13, 1'b0, 8'h80, 8'h00, 16'd1, 16'd0);
    vecs[9]  = mk(16'h0000, 16'hF7F7, 12, 14, 1'b0, 8'h80, 8'h00, 16'd2, 16'd0);
    vecs[10] = mk(16'h0000, 16'h0FF0, 13, 15, 1'b0, 8'h7F, 8'hFF, 16'd3, 16'd0);
    vecs[11] = mk(16'h0000, 16'h0FF8, 31, 31, 1'b1, 8'h7F, 8'hFF, 16'd4, 16'd1);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_out_done", 32'(out_done), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Backpressure: out_ready low, in_valid high for 12 cycles
    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 9; k++) p[k] = 16'(i * 8);
      b = 16'(i); row = 5'(i); col = 5'(31 - i);
      drive_set(p, b, row, col, 1'b0);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back({1'b0, row, col, model(p, b)});
        acc_n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc_n), 32'd8);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_head", 32'({out_done, out_row, out_col, out_data}), 32'(exp_q[0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    popped = 0;
    cyc = 0;
    while (popped < 8 && cyc < 50) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("bp_extra", 32'd1, 32'd0);
        else chk("bp_order", 32'({out_done, out_row, out_col, out_data}), 32'(exp_q.pop_front()));
        popped++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("bp_popped", 32'(popped), 32'd8);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_queue", 32'(exp_q.size()), 32'd0);

    // Reset while results are in flight
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 9; k++) p[k] = 16'h1000;
      drive_set(p, 16'h0000, 5'(i), 5'(i), 1'b0);
      in_valid = 1'b1;
      chk("rst_fill_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_sat", 32'(sat_cnt), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    stale = 0;
    repeat (20) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("rst_mid_stale", 32'(stale), 32'd0);

    // Random handshakes over 1000 sets, checked against the model
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (sent < 1000 && $urandom_range(0, 9) < 7) begin
        for (int k = 0; k < 9; k++) p[k] = 16'($urandom_range(0, 400)) - 16'd200;
        b = 16'($urandom_range(0, 2000)) - 16'd1000;
        drive_set(p, b, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_extra", 32'd1, 32'd0);
        else chk("rand_result", 32'({out_done, out_row, out_col, out_data}), 32'(exp_q.pop_front()));
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_done, in_row, in_col, model(p, b)});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_got", 32'(got), 32'd1000);
    chk("rand_queue", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_accum_stage.md
CONV_ACCUM_STAGE -- requirements
Module: conv_accum_stage

Interface
REQ-001 Parameter M, default 8: operand width; products are 2*M bits, two's complement.
REQ-002 Parameter SHIFT, default 4: requantization right-shift amount, 1..8.
REQ-003 Parameter DEPTH, default 8: output FIFO entries, power of two, at least 4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  product set on d11..d33 is valid this cycle.
REQ-007 in_ready  out  1  stage accepts a set this cycle; transfer when in_valid and in_ready are both high.
REQ-008 d11..d33  in  2*M each  nine signed 3x3 window products.
REQ-009 bias  in  16  signed bias, sampled with the set.
REQ-010 in_row, in_col  in  5 each  pixel coordinates travelling with the set.
REQ-011 in_done  in  1  marks the last pixel of a frame.
REQ-012 out_valid  out  1  out_* fields hold a valid result.
REQ-013 out_ready  in  1  downstream accepts; transfer when out_valid and out_ready are both high.
REQ-014 out_data  out  8  requantized pixel.
REQ-015 out_row, out_col  out  5 each  coordinates of out_data.
REQ-016 out_done  out  1  frame-end flag of out_data.
REQ-017 sat_cnt  out  16  count of clipped results.

Function
REQ-018 Stage 1 SHALL register five partial sums of the nine sign-extended products, each 20 bits wide.
REQ-019 Stage 2 SHALL register acc = the sum of the partial sums plus sign-extended bias, 20-bit signed; this width never overflows.
REQ-020 Stage 3 SHALL compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), clip r per REQ-031/032, and write the result into the FIFO.
REQ-021 row, col and done SHALL travel with the data through every stage unchanged.
REQ-022 Latency: a set accepted at edge k SHALL appear on out_* with out_valid high after edge k+4 when the FIFO is empty.
REQ-023 Each pipeline stage SHALL carry a valid bit; stages SHALL always advance, with no stall inside the pipe.
REQ-024 in_ready SHALL equal (fifo_count + number of valid stages 1..3) < DEPTH, so FIFO overflow is impossible.
REQ-025 The FIFO SHALL preserve order; out_* SHALL be driven from a registered head entry and SHALL hold stable while out_valid is high and out_ready is low.
REQ-026 When the FIFO is full and a pop occurs, a simultaneous write SHALL succeed in the same cycle.
REQ-027 When the FIFO is empty, out_valid SHALL be low and out_* SHALL hold their last value.
REQ-028 sat_cnt SHALL increment once for each result clipped at stage 3, and SHALL saturate at 16'hFFFF with no wrap.
REQ-029 sat_cnt SHALL clear at the cycle after a result with out_done high is popped, unless that same cycle also increments it, in which case sat_cnt SHALL become 1.

Reset
REQ-030 While rst is high at a rising edge: all stage valid bits, the FIFO pointers, fifo_count and sat_cnt SHALL clear; out_valid=0, out_data=0, out_row=0, out_col=0, out_done=0; in_ready=1 in the cycle after reset. Reset mid-operation SHALL discard all in-flight and buffered results.

Configuration
REQ-031 With CONV_RELU_EN defined: r < 0 gives out_data = 0, which is not counted as saturation; r > 255 gives out_data = 255, counted; out_data is unsigned.
REQ-032 Without CONV_RELU_EN: r is clipped to the range -128..127 and output as two's complement; either clip is counted.

Verification
REQ-033 Each of the nine products = 16'h0010, bias = 0, SHIFT = 4 -> out_data = 9 exactly 4 cycles after acceptance, with row/col echoed.
REQ-034 Each product = 16'hFFF0, bias = 0 -> with CONV_RELU_EN, out_data = 0 and sat_cnt unchanged; without it, out_data = 8'hF7 (-9).
REQ-035 Each product = 16'h1000 -> out_data = 255 (8'h7F without the macro), sat_cnt = 1; pop with out_done=1 -> sat_cnt = 0 the next cycle.
REQ-036 out_ready held low, in_valid held high for 12 cycles -> exactly 8 sets accepted, in_ready low thereafter; release out_ready -> 8 results in order with no loss or duplication.
REQ-037 Random in_valid/out_ready over 1000 sets vs. reference model -> all results match, in order.
REQ-038 Assert rst for 1 cycle with 5 results in flight -> out_valid = 0 next cycle, no stale result ever emitted, sat_cnt = 0.
